// File: rtl/uart_tx_cfg_if.sv
// Producer-side bundle for uart_tx_cfg.
// It carries the frame configuration, the request/ready handshake, the status outputs and the serial line.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
);
   logic [DIV_W-1:0]     DIV;
   logic [3:0]           NBITS;
   logic [1:0]           PARITY_MODE;
   logic                 STOP2;
   logic [DATA_BITS-1:0] TXDATA;
   logic                 TX_RQ;
   logic                 TX_RDY;
   logic                 TX_BUSY;
   logic                 TX_DONE;
   logic                 TXD;

   modport master (
      output DIV, NBITS, PARITY_MODE, STOP2, TXDATA, TX_RQ,
      input  TX_RDY, TX_BUSY, TX_DONE, TXD
   );

   modport slave (
      input  DIV, NBITS, PARITY_MODE, STOP2, TXDATA, TX_RQ,
      output TX_RDY, TX_BUSY, TX_DONE, TXD
   );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with an internal baud divider.
// The frame is a start bit, then 5..DATA_BITS data bits sent LSB first, then an optional parity bit, then one or two stop bits.
// The whole configuration is captured at accept and stays fixed for the rest of the frame.
module uart_tx_cfg #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input logic         CLK,
   input logic         R,
   uart_tx_cfg_if.slave bus
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [3:0]       NB_MAX  = 4'(DATA_BITS);
   localparam logic [3:0]       NB_MIN  = 4'd5;

   state_t               state, state_nxt;
   logic [DIV_W-1:0]     div_cnt, div_nxt, div_q;
   logic [3:0]           bit_cnt, bit_nxt, nbits_q, nbits_in;
   logic [DATA_BITS-1:0] shreg, shreg_nxt, used_mask;
   logic                 par_en_q, par_q, stop2_q, par_in;
   logic                 txd_q, txd_nxt;
   logic                 accept, wrap, last_data, last_stop;

   assign accept    = (state == IDLE) && bus.TX_RQ;
   assign wrap      = (div_cnt == div_q - DIV_ONE);
   assign last_data = (bit_cnt == nbits_q - 4'd1);
   assign last_stop = (bit_cnt == {3'b000, stop2_q});

   // Clamp the requested width and precompute the parity bit from the live inputs, for use at the accept edge
   always_comb begin
      nbits_in = (bus.NBITS < NB_MIN || bus.NBITS > NB_MAX) ? NB_MAX : bus.NBITS;
      for (int i = 0; i < DATA_BITS; i++) begin
         used_mask[i] = (i < int'(nbits_in));
      end
      par_in = (^(bus.TXDATA & used_mask)) ^ (bus.PARITY_MODE == 2'b10);
   end

   // State, counters, shifter and the registered serial line; R has priority over everything
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      if (R) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         txd_q    <= 1'b1;
         div_q    <= DIV_ONE;
         nbits_q  <= NB_MAX;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         shreg   <= shreg_nxt;
         txd_q   <= txd_nxt;
         if (accept) begin
            div_q    <= (bus.DIV == '0) ? DIV_ONE : bus.DIV;
            nbits_q  <= nbits_in;
            par_en_q <= ^bus.PARITY_MODE;
            par_q    <= par_in;
            stop2_q  <= bus.STOP2;
         end
      end
   end

   // Next state: bits advance on divider wrap; the bit counter indexes data bits, then stop bits
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
      state_nxt = state;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      if (state == IDLE) begin
         if (accept) begin
            state_nxt = START;
            div_nxt   = '0;
            bit_nxt   = '0;
            shreg_nxt = bus.TXDATA;
         end
      end else if (!wrap) begin
         div_nxt = div_cnt + DIV_ONE;
      end else begin
         div_nxt = '0;
         unique case (state)
            START: begin
               state_nxt = DATA;
               bit_nxt   = '0;
            end
            DATA: begin
               if (last_data) begin
                  state_nxt = par_en_q ? PARITY : STOP;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt   = bit_cnt + 4'd1;
                  shreg_nxt = shreg >> 1;
               end
            end
            PARITY: begin
               state_nxt = STOP;
               bit_nxt   = '0;
            end
            STOP: begin
               if (last_stop) begin
                  state_nxt = IDLE;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt = bit_cnt + 4'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs: status from the current state, and the serial level for the state being entered
   always_comb begin
      bus.TX_RDY  = (state == IDLE);
      bus.TX_BUSY = (state != IDLE);
      bus.TX_DONE = (state == STOP) && wrap && last_stop;
      unique case (state_nxt)
         IDLE:    txd_nxt = 1'b1;
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = shreg_nxt[0];
         PARITY:  txd_nxt = par_q;
         STOP:    txd_nxt = 1'b1;
         default: txd_nxt = 1'b1;
      endcase
   end

   assign bus.TXD = txd_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg.
// Each frame's expected per-cycle line trace is pushed to a scoreboard when the frame is requested.
// The trace is then popped and compared, cycle by cycle, on the falling edge.
module tb_uart_tx_cfg;

   localparam int DATA_BITS = 9;
   localparam int DIV_W     = 16;

   logic CLK = 1'b0;
   logic R   = 1'b1;

   uart_tx_cfg_if #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) bus ();

   uart_tx_cfg #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) dut (
      .CLK (CLK),
      .R   (R),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic txd;
      logic done;
      logic rdy;
      logic busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push_bit(input logic b, input int divq, input bit last);
      for (int c = 0; c < divq; c++) begin
         exp_q.push_back('{txd: b, done: (last && c == divq - 1), rdy: 1'b0, busy: 1'b1});
      end
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back('{txd: 1'b1, done: 1'b0, rdy: 1'b1, busy: 1'b0});
   endtask

   // Reference frame: start, used data bits LSB first, optional parity, stop bit(s)
   task automatic push_frame(input logic [DATA_BITS-1:0] data, input int nbits, input logic [1:0] pm,
                             input logic s2, input int div);
      int   divq;
      int   nb;
      logic p;
      divq = (div == 0) ? 1 : div;
      nb   = (nbits < 5 || nbits > DATA_BITS) ? DATA_BITS : nbits;
      p    = 1'b0;
      push_bit(1'b0, divq, 1'b0);
      for (int i = 0; i < nb; i++) begin
         push_bit(data[i], divq, 1'b0);
         p ^= data[i];
      end
      if (pm == 2'b01) push_bit(p, divq, 1'b0);
      if (pm == 2'b10) push_bit(~p, divq, 1'b0);
      push_bit(1'b1, divq, !s2);
      if (s2) push_bit(1'b1, divq, 1'b1);
   endtask

   task automatic drive(input logic [DATA_BITS-1:0] data, input int nbits, input logic [1:0] pm,
                        input logic s2, input int div);
      bus.TXDATA      = data;
      bus.NBITS       = 4'(nbits);
      bus.PARITY_MODE = pm;
      bus.STOP2       = s2;
      bus.DIV         = DIV_W'(div);
      bus.TX_RQ       = 1'b1;
   endtask

   // Issue one request from an idle falling edge and queue its trace plus the following idle cycle
   task automatic start_frame(input logic [DATA_BITS-1:0] data, input int nbits, input logic [1:0] pm,
                              input logic s2, input int div);
      drive(data, nbits, pm, s2, div);
      push_frame(data, nbits, pm, s2, div);
      push_idle(1);
      @(posedge CLK);
      #1 bus.TX_RQ = 1'b0;
   endtask

   task automatic drain(input string tag, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s cyc=%0d scoreboard empty", tag, k);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_txd"},  k, 32'(bus.TXD),     32'(e.txd));
            check({tag, "_done"}, k, 32'(bus.TX_DONE), 32'(e.done));
            check({tag, "_rdy"},  k, 32'(bus.TX_RDY),  32'(e.rdy));
            check({tag, "_busy"}, k, 32'(bus.TX_BUSY), 32'(e.busy));
         end
      end
   endtask

   task automatic drain_all(input string tag);
      drain(tag, exp_q.size());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      bus.TX_RQ       = 1'b0;
      bus.DIV         = '0;
      bus.NBITS       = 4'd8;
      bus.PARITY_MODE = 2'b00;
      bus.STOP2       = 1'b0;
      bus.TXDATA      = '0;
      R = 1'b1;
      repeat (3) @(posedge CLK);

      // Reset state, sampled while R is still high
      @(negedge CLK);
      check("rst_txd",  0, 32'(bus.TXD),     32'd1);
      check("rst_rdy",  0, 32'(bus.TX_RDY),  32'd1);
      check("rst_busy", 0, 32'(bus.TX_BUSY), 32'd0);
      check("rst_done", 0, 32'(bus.TX_DONE), 32'd0);
      R = 1'b0;
      push_idle(2);
      drain_all("idle");

      // 8N1, DIV=4, 0xA5
      start_frame(9'h0A5, 8, 2'b00, 1'b0, 4);
      drain_all("a5_8n1");

      // Even and odd parity on the same data
      start_frame(9'h0A5, 8, 2'b01, 1'b0, 4);
      drain_all("a5_even");
      start_frame(9'h0A5, 8, 2'b10, 1'b0, 4);
      drain_all("a5_odd");

      // DIV=0 maps to 1; bit 8 is excluded from both data and parity
      start_frame(9'h1FF, 7, 2'b01, 1'b1, 0);
      drain_all("n7_even_2stop");

      // Out-of-range NBITS clamps to DATA_BITS; PARITY_MODE=11 means none
      start_frame(9'h155, 3, 2'b11, 1'b0, 1);
      drain_all("clamp_lo");
      start_frame(9'h0F3, 15, 2'b10, 1'b0, 2);
      drain_all("clamp_hi");

      // Wide divisor
      start_frame(9'h012, 5, 2'b00, 1'b1, 300);
      drain_all("wide_div");

      // Back-to-back with TX_RQ held; TXDATA changed during frame 1
      drive(9'h03C, 8, 2'b00, 1'b0, 2);
      push_frame(9'h03C, 8, 2'b00, 1'b0, 2);
      push_idle(1);
      push_frame(9'h0C3, 8, 2'b00, 1'b0, 2);
      push_idle(1);
      @(posedge CLK);
      #1 bus.TXDATA = 9'h0C3;
      drain("b2b_f1", 21);
      @(posedge CLK);
      #1 bus.TX_RQ = 1'b0;
      drain_all("b2b_f2");

      // One-cycle reset in the middle of the data bits
      start_frame(9'h0A5, 8, 2'b00, 1'b0, 4);
      drain("pre_reset", 10);
      exp_q.delete();
      R = 1'b1;
      @(posedge CLK);
      #1 R = 1'b0;
      push_idle(45);
      drain_all("post_reset");
      start_frame(9'h03C, 8, 2'b10, 1'b1, 3);
      drain_all("after_reset");

      // Mid-frame configuration changes and a stray request are ignored until the next accept
      start_frame(9'h05A, 8, 2'b01, 1'b0, 3);
      bus.DIV         = 16'd1;
      bus.PARITY_MODE = 2'b10;
      bus.NBITS       = 4'd5;
      bus.STOP2       = 1'b1;
      bus.TXDATA      = '0;
      drain("cfg_hold", 5);
      bus.TX_RQ = 1'b1;
      drain("cfg_hold_rq", 1);
      bus.TX_RQ = 1'b0;
      drain_all("cfg_hold_rest");
      start_frame(9'h000, 5, 2'b10, 1'b1, 1);
      drain_all("cfg_new");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
